accum_drain: RTL and testbench

Output drain stage directly downstream of the MVM accumulator. It captures each completed dot-product result when the accumulator's `ovalid` pulses, rescales it by a runtime arithmetic right shift, and narrows it to the output width. Results are queued in a first-word-fall-through FIFO and presented on a valid/ready stream tagged with an end-of-vector marker. The accumulator has no backpressure, so the block raises `almost_full` for the controller to stall issue, and flags any overflow it cannot absorb.

---
 rtl/mvm_pkg.sv | 15 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/accum_drain.sv | 108 ++++++++++
 tb/tb_accum_drain.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared MVM datapath defaults: accumulator/output widths and derived port-width helpers.
package mvm_pkg;

    localparam int ACCUMW_DEF = 32;
    localparam int OUTW_DEF   = 16;

    function automatic int shift_w(input int accumw);
        return $clog2(accumw);
    endfunction

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered occupancy, valid and almost-full.
module sync_fifo #(
    parameter int WIDTH       = 17,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 14,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic [CW-1:0]    count,
    output logic             afull,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_next;

    // A push into a full queue is still accepted when the head leaves in the same cycle.
    assign full       = (count == CW'(DEPTH));
    assign do_pop     = pop && rvalid;
    assign do_push    = push && (!full || do_pop);
    assign count_next = count + CW'(do_push) - CW'(do_pop);
    assign rdata      = rvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            rvalid <= 1'b0;
            afull  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count  <= count_next;
            rvalid <= (count_next != '0);
            afull  <= (count_next >= CW'(AFULL_LEVEL));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/accum_drain.sv
// Accumulator drain: shift/narrow each result, tag vector ends, queue into a FWFT FIFO.
// Define ACCUM_DRAIN_SAT_EN to saturate on narrowing (sticky sat); default wraps to the low OUTW bits.
module accum_drain
    import mvm_pkg::*;
#(
    parameter int ACCUMW       = ACCUMW_DEF,
    parameter int OUTW         = OUTW_DEF,
    parameter int DEPTH        = 16,
    parameter int ROWS         = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [ACCUMW-1:0]    idata,
    input  logic                        ivalid,
    input  logic [shift_w(ACCUMW)-1:0]  shift,
    output logic signed [OUTW-1:0]      odata,
    output logic                        olast,
    output logic                        ovalid,
    input  logic                        oready,
    output logic [count_w(DEPTH)-1:0]   count,
    output logic                        almost_full,
    output logic                        overflow,
    output logic                        sat
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic signed [ACCUMW-1:0] OUT_MAX = {{(ACCUMW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
    localparam logic signed [ACCUMW-1:0] OUT_MIN = {{(ACCUMW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

    logic [RW-1:0]            row;
    logic signed [ACCUMW-1:0] shifted_p0;
    logic                     vld_p1;
    logic                     last_p1;
    logic signed [OUTW-1:0]   data_p1;
    logic [OUTW:0]            head;
    logic                     fifo_full;

`ifdef ACCUM_DRAIN_SAT_EN
    function automatic logic signed [OUTW-1:0] narrow(input logic signed [ACCUMW-1:0] v);
        if (v > OUT_MAX) return OUT_MAX[OUTW-1:0];
        if (v < OUT_MIN) return OUT_MIN[OUTW-1:0];
        return v[OUTW-1:0];
    endfunction

    function automatic logic clamps(input logic signed [ACCUMW-1:0] v);
        return (v > OUT_MAX) || (v < OUT_MIN);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)                               sat <= 1'b0;
        else if (ivalid && clamps(shifted_p0)) sat <= 1'b1;
    end
`else
    function automatic logic signed [OUTW-1:0] narrow(input logic signed [ACCUMW-1:0] v);
        return v[OUTW-1:0];
    endfunction

    assign sat = 1'b0;
`endif

    assign shifted_p0 = idata >>> shift;

    // Stage 0 -> 1: rescale and tag; the row counter counts every strobe, dropped or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            row    <= '0;
        end else begin
            vld_p1 <= ivalid;
            if (ivalid) row <= (row == RW'(ROWS-1)) ? '0 : row + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (ivalid) begin
            data_p1 <= narrow(shifted_p0);
            last_p1 <= (row == RW'(ROWS-1));
        end
    end

    // Stage 1 -> queue: a full queue with no departing head loses the entry.
    always_ff @(posedge clk) begin
        if (rst)                                       overflow <= 1'b0;
        else if (vld_p1 && fifo_full && !(ovalid && oready)) overflow <= 1'b1;
    end

    sync_fifo #(
        .WIDTH      (OUTW + 1),
        .DEPTH      (DEPTH),
        .AFULL_LEVEL(DEPTH - AFULL_MARGIN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_p1),
        .pop   (oready),
        .wdata ({last_p1, data_p1}),
        .rdata (head),
        .rvalid(ovalid),
        .count (count),
        .afull (almost_full),
        .full  (fifo_full)
    );

    assign olast = head[OUTW];
    assign odata = head[OUTW-1:0];

endmodule

// File: tb/tb_accum_drain.sv
// Randomised self-checking bench for accum_drain against a queue-based reference model.
module tb_accum_drain;

    localparam int DEPTH = 16;
    localparam int ROWS  = 8;
    localparam int AFM   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [31:0] idata = '0;
    logic               ivalid = 1'b0;
    logic [4:0]         shift = '0;
    logic signed [15:0] odata;
    logic               olast;
    logic               ovalid;
    logic               oready = 1'b0;
    logic [4:0]         count;
    logic               almost_full;
    logic               overflow;
    logic               sat;

    wire [25:0] dut_vec = {ovalid, odata, olast, count, almost_full, overflow, sat};

    int tests = 0;
    int fails = 0;

    logic [16:0] mq[$];
    bit          pend_v;
    logic [16:0] pend_e;
    int          mrow;
    bit          movf;
    bit          msat;

    accum_drain #(
        .ACCUMW(32), .OUTW(16), .DEPTH(DEPTH), .ROWS(ROWS), .AFULL_MARGIN(AFM)
    ) dut (
        .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .shift(shift),
        .odata(odata), .olast(olast), .ovalid(ovalid), .oready(oready),
        .count(count), .almost_full(almost_full), .overflow(overflow), .sat(sat)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] mk_entry(input logic signed [31:0] d, input int sh,
                                             input bit last, output bit clamp);
        longint v;
        logic [15:0] r;
        v = longint'(d) >>> sh;
        r = v[15:0];
        clamp = 1'b0;
`ifdef ACCUM_DRAIN_SAT_EN
        if (v > 32767)       begin r = 16'h7FFF; clamp = 1'b1; end
        else if (v < -32768) begin r = 16'h8000; clamp = 1'b1; end
`endif
        return {last, r};
    endfunction

    function automatic logic [25:0] model_vec();
        bit ne;
        ne = (mq.size() > 0);
        return {ne, ne ? mq[0][15:0] : 16'h0, ne ? mq[0][16] : 1'b0, 5'(mq.size()),
                mq.size() >= DEPTH - AFM, movf, msat};
    endfunction

    task automatic model_clear();
        mq.delete();
        pend_v = 0; mrow = 0; movf = 0; msat = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; ivalid = 1'b0; oready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic step(input logic signed [31:0] d, input bit v, input int sh, input bit rdy);
        bit pop;
        bit clamp;
        idata = d; ivalid = v; shift = 5'(sh); oready = rdy;
        @(posedge clk);
        pop = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (pend_v) begin
            if (mq.size() < DEPTH) mq.push_back(pend_e);
            else movf = 1;
        end
        pend_v = v;
        if (v) begin
            pend_e = mk_entry(d, sh, mrow == ROWS - 1, clamp);
            if (clamp) msat = 1;
            mrow = (mrow + 1) % ROWS;
        end
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (dut_vec !== 26'h0) begin
            fails++; $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 26'h0);
        end
    endtask

    task automatic test_single();
        do_reset();
        step(32'h0000_1234, 1, 4, 0);
        tests++;
        if (ovalid !== 1'b0) begin fails++; $display("FAIL single_n1_ovalid got=%b exp=0", ovalid); end
        step(0, 0, 0, 0);
        tests++;
        if ({ovalid, odata, olast} !== {1'b1, 16'h0123, 1'b0}) begin
            fails++; $display("FAIL single_n2 got=%b/%h/%b exp=1/0123/0", ovalid, odata, olast);
        end
        step(0, 0, 0, 1);
        tests++;
        if (dut_vec !== model_vec()) begin
            fails++; $display("FAIL single_pop got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_framing();
        int n_out = 0;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step($urandom, i < 16, $urandom_range(0, 31), 1);
            tests++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL framing cyc=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (ovalid) begin
                n_out++;
                tests++;
                if (olast !== (n_out % 8 == 0)) begin
                    fails++; $display("FAIL framing_olast res=%0d got=%b exp=%b", n_out, olast, n_out % 8 == 0);
                end
            end
        end
        tests++;
        if (n_out != 16) begin fails++; $display("FAIL framing_count got=%0d exp=16", n_out); end
    endtask

    task automatic test_narrow();
        logic signed [31:0] din [3];
        int                 sh  [3];
        logic [15:0]        exp [3];
        din[0] = 32'h0010_0000; sh[0] = 0;
        din[1] = 32'hFFF0_0000; sh[1] = 0;
        din[2] = -32'sd7;       sh[2] = 1;
`ifdef ACCUM_DRAIN_SAT_EN
        exp[0] = 16'h7FFF; exp[1] = 16'h8000;
`else
        exp[0] = 16'h0000; exp[1] = 16'h0000;
`endif
        exp[2] = 16'hFFFC;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(din[k], 1, sh[k], 0);
            step(0, 0, 0, 0);
            tests++;
            if (odata !== exp[k]) begin
                fails++; $display("FAIL narrow_%0d got=%h exp=%h", k, odata, exp[k]);
            end
            tests++;
`ifdef ACCUM_DRAIN_SAT_EN
            if (sat !== 1'b1) begin fails++; $display("FAIL narrow_sat_%0d got=%b exp=1", k, sat); end
`else
            if (sat !== 1'b0) begin fails++; $display("FAIL narrow_sat_%0d got=%b exp=0", k, sat); end
`endif
            step(0, 0, 0, 1);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 19; i++) begin
            step(i + 1, i < 17, 0, 0);
            tests++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL fill cyc=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
            if (count == 5'd14 || count == 5'd13) begin
                tests++;
                if (almost_full !== (count == 5'd14)) begin
                    fails++; $display("FAIL fill_afull count=%0d got=%b", count, almost_full);
                end
            end
        end
        tests++;
        if ({count, overflow} !== {5'd16, 1'b1}) begin
            fails++; $display("FAIL fill_full got=%0d/%b exp=16/1", count, overflow);
        end
        for (int k = 1; k <= 16; k++) begin
            tests++;
            if ({ovalid, odata, olast} !== {1'b1, 16'(k), k % 8 == 0}) begin
                fails++; $display("FAIL drain_%0d got=%b/%h/%b exp=1/%h/%b", k, ovalid, odata, olast, 16'(k), k % 8 == 0);
            end
            step(0, 0, 0, 1);
        end
        tests++;
        if (ovalid !== 1'b0) begin fails++; $display("FAIL drain_empty got=%b exp=0", ovalid); end
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 18; i++) step($urandom, i < 16, $urandom_range(0, 31), 0);
        tests++;
        if (count !== 5'd16) begin fails++; $display("FAIL fpp_fill got=%0d exp=16", count); end
        step(32'h99, 1, 0, 0);
        step(0, 0, 0, 1);
        tests++;
        if ({count, overflow} !== {5'd16, 1'b0}) begin
            fails++; $display("FAIL fpp_same_cycle got=%0d/%b exp=16/0", count, overflow);
        end
        tests++;
        if (dut_vec !== model_vec()) begin
            fails++; $display("FAIL fpp_model got=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_reset_mid();
        int n_out = 0;
        do_reset();
        for (int i = 0; i < 8; i++) step($urandom, i < 6, 0, 1);
        for (int i = 0; i < 7; i++) step($urandom, i < 5, 0, 0);
        tests++;
        if (count !== 5'd5 || mrow != 3) begin
            fails++; $display("FAIL rmid_setup got=%0d exp=5 (row %0d)", count, mrow);
        end
        do_reset();
        tests++;
        if (dut_vec !== 26'h0) begin fails++; $display("FAIL rmid_zero got=%h exp=%h", dut_vec, 26'h0); end
        for (int i = 0; i < 10; i++) begin
            step($urandom, i < 8, $urandom_range(0, 31), 1);
            if (ovalid) begin
                n_out++;
                tests++;
                if (olast !== (n_out == 8)) begin
                    fails++; $display("FAIL rmid_olast res=%0d got=%b exp=%b", n_out, olast, n_out == 8);
                end
            end
        end
        tests++;
        if (n_out != 8) begin fails++; $display("FAIL rmid_count got=%0d exp=8", n_out); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            int bias;
            bias = (i < 250) ? 50 : 85;
            step($urandom, $urandom_range(0, 99) < 70, $urandom_range(0, 31),
                 $urandom_range(0, 99) < bias);
            tests++;
            if (dut_vec !== model_vec()) begin
                fails++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_framing();
        test_narrow();
        test_fill_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
